// File: rtl/key_expansion.sv
`default_nettype none
// key_expansion: streams the AES key schedule w[0..T-1], one word per valid/ready handshake.
// Optional build macro KEY_EXPANSION_LAST_KEY_EN adds last_key, the final Nk schedule words.
module key_expansion #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_word,
  output logic [5:0]          out_index,
`ifdef KEY_EXPANSION_LAST_KEY_EN
  output logic [KEY_BITS-1:0] last_key,
`endif
  output logic                done
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int T  = 4 * (NR + 1);
  localparam logic [5:0] LAST_INDEX = 6'(T - 1);
  localparam logic [2:0] LAST_POS   = 3'(NK - 1);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_next;
  // win[0] is the word on out_word; win[NK-1] is the newest word held
  logic [31:0] win [NK];
  logic [2:0]  pos;
  logic [3:0]  round;
  logic [31:0] temp, next_word;
  logic        handshake;

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign handshake = (state == EMIT) && out_ready;
  assign busy      = (state != IDLE);
  assign out_valid = (state == EMIT);
  assign done      = (state == DONE);
  assign out_word  = win[0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = EMIT;
      EMIT:    if (handshake && out_index == LAST_INDEX) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The word entering the window is w[out_index+NK]; pos and round track its i mod NK and i/NK-1.
  always_comb begin
    temp = win[NK-1];
    if (pos == 3'd0)
      temp = sub_word({win[NK-1][23:0], win[NK-1][31:24]}) ^ {rcon(round), 24'h0};
    else if (NK == 8 && pos == 3'd4)
      temp = sub_word(win[NK-1]);
    next_word = win[0] ^ temp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NK; j++) win[j] <= '0;
      out_index <= '0;
      pos       <= '0;
      round     <= '0;
    end else if (state == IDLE && start) begin
      for (int j = 0; j < NK; j++) win[j] <= key[KEY_BITS-1-32*j -: 32];
      out_index <= '0;
      pos       <= '0;
      round     <= '0;
    end else if (handshake) begin
      for (int j = 0; j < NK - 1; j++) win[j] <= win[j+1];
      win[NK-1] <= next_word;
      out_index <= out_index + 6'd1;
      if (pos == LAST_POS) begin
        pos   <= '0;
        round <= round + 4'd1;
      end else begin
        pos <= pos + 3'd1;
      end
    end
  end

`ifdef KEY_EXPANSION_LAST_KEY_EN
  // history keeps the NK-1 words accepted before the current one
  logic [KEY_BITS-33:0] history;

  always_ff @(posedge clk) begin
    if (rst) begin
      history  <= '0;
      last_key <= '0;
    end else if (handshake) begin
      history <= {history[KEY_BITS-65:0], win[0]};
      if (out_index == LAST_INDEX) last_key <= {history, win[0]};
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_key_expansion.sv
`default_nettype none
// tb_key_expansion: scoreboard bench for 128/192/256-bit instances against a
// reference key schedule built from a GF(2^8)-derived S-box.
module tb_key_expansion;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_s [3];
  logic [255:0] key_s  [3];
  logic        ready_s [3];
  logic        busy_s  [3];
  logic        valid_s [3];
  logic        done_s  [3];
  logic [31:0] word_s  [3];
  logic [5:0]  idx_s   [3];
`ifdef KEY_EXPANSION_LAST_KEY_EN
  logic [255:0] last_key_s [3];
  logic [255:0] exp_lk;
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int KB = 128 + 64 * g;
`ifdef KEY_EXPANSION_LAST_KEY_EN
    logic [KB-1:0] lk;
    assign last_key_s[g] = 256'(lk);
`endif
    key_expansion #(.KEY_BITS(KB)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start_s[g]),
      .key       (key_s[g][KB-1:0]),
      .busy      (busy_s[g]),
      .out_valid (valid_s[g]),
      .out_ready (ready_s[g]),
      .out_word  (word_s[g]),
      .out_index (idx_s[g]),
`ifdef KEY_EXPANSION_LAST_KEY_EN
      .last_key  (lk),
`endif
      .done      (done_s[g])
    );
  end

  // ---------------- reference model ----------------
  logic [7:0]  sbox_m [256];
  logic [7:0]  rc_m   [10];
  logic [31:0] mw     [60];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_calc(input int x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] msub(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  task automatic expand(input int nk, input logic [255:0] k);
    int t = 4 * (nk + 7);
    logic [31:0] tmp;
    for (int i = 0; i < nk; i++) mw[i] = k[nk*32-1-32*i -: 32];
    for (int i = nk; i < t; i++) begin
      tmp = mw[i-1];
      if (i % nk == 0)
        tmp = msub({tmp[23:0], tmp[31:24]}) ^ {rc_m[i/nk-1], 24'h0};
      else if (nk == 8 && i % nk == 4)
        tmp = msub(tmp);
      mw[i] = mw[i-nk] ^ tmp;
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [39:0] exp_q [$];
  int          checks = 0;
  int          failures = 0;

  int          snap_seq = 0, snap_g = 0;
  logic [40:0] snap_exp;
  string       snap_name;
  int          tmo_seq = 0;
  int          end_seq = 0;

  logic        held [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] held_word [3];
  logic [5:0]  held_idx [3];
  logic        done_due [3] = '{1'b0, 1'b0, 1'b0};
  int          snap_seen = 0, tmo_seen = 0, end_seen = 0;

  always @(negedge clk) begin
    logic [39:0] e;
    logic [40:0] act;
    for (int g = 0; g < 3; g++) begin
      if (held[g] && valid_s[g]) begin
        checks++;
        if (word_s[g] !== held_word[g] || idx_s[g] !== held_idx[g]) begin
          failures++;
          $display("FAIL stall_hold inst=%0d actual idx=%0d word=%h required idx=%0d word=%h",
                   g, idx_s[g], word_s[g], held_idx[g], held_word[g]);
        end
      end
      held[g]      = valid_s[g] && !ready_s[g];
      held_word[g] = word_s[g];
      held_idx[g]  = idx_s[g];

      if (done_s[g] || done_due[g]) begin
        checks++;
        if (done_s[g] !== done_due[g]) begin
          failures++;
          $display("FAIL done_pulse inst=%0d actual=%b required=%b", g, done_s[g], done_due[g]);
        end
`ifdef KEY_EXPANSION_LAST_KEY_EN
        if (done_due[g]) begin
          checks++;
          if (last_key_s[g] !== exp_lk) begin
            failures++;
            $display("FAIL last_key inst=%0d actual=%h required=%h", g, last_key_s[g], exp_lk);
          end
        end
`endif
      end
      done_due[g] = 1'b0;

      if (valid_s[g] === 1'b1 && ready_s[g]) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word inst=%0d actual idx=%0d word=%h required none", g, idx_s[g], word_s[g]);
        end else begin
          e = exp_q.pop_front();
          if ({2'(g), idx_s[g], word_s[g]} !== e) begin
            failures++;
            $display("FAIL word inst=%0d actual idx=%0d word=%h required inst=%0d idx=%0d word=%h",
                     g, idx_s[g], word_s[g], e[39:38], e[37:32], e[31:0]);
          end
          if (int'(e[37:32]) == 4 * (4 + 2 * g + 7) - 1) done_due[g] = 1'b1;
        end
      end
    end

    if (snap_seq != snap_seen) begin
      snap_seen = snap_seq;
      checks++;
      act = {busy_s[snap_g], valid_s[snap_g], done_s[snap_g], idx_s[snap_g], word_s[snap_g]};
      if (act !== snap_exp) begin
        failures++;
        $display("FAIL %s inst=%0d actual busy,valid,done,idx,word=%h required=%h",
                 snap_name, snap_g, act, snap_exp);
      end
    end
    while (tmo_seen != tmo_seq) begin
      tmo_seen++;
      checks++;
      failures++;
      $display("FAIL timeout actual=no_done required=done");
    end
    if (end_seq != end_seen) begin
      end_seen = end_seq;
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL leftover_words actual=%0d required=0", exp_q.size());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic snapshot(input int g, input logic [40:0] expv, input string name);
    snap_g    = g;
    snap_exp  = expv;
    snap_name = name;
    snap_seq++;
  endtask

  task automatic run_key(input int g, input logic [255:0] k, input bit stall,
                         input bit repulse, input int abort_at, input bit kat);
    int nk = 4 + 2 * g;
    int t  = 4 * (nk + 7);
    bit seen = 1'b0;
    expand(nk, k);
    if (kat) begin
      case (g)
        0: begin mw[4] = 32'ha0fafe17; mw[43] = 32'hb6630ca6; end
        1: begin mw[6] = 32'hfe0c91f7; mw[51] = 32'h01002202; end
        default: begin mw[8] = 32'h9ba35411; mw[59] = 32'h706c631e; end
      endcase
    end
    for (int i = 0; i < t; i++) exp_q.push_back({2'(g), 6'(i), mw[i]});
`ifdef KEY_EXPANSION_LAST_KEY_EN
    exp_lk = '0;
    for (int j = 0; j < nk; j++) exp_lk = {exp_lk[223:0], mw[t-nk+j]};
    if (kat && g == 0) exp_lk = 256'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`endif
    key_s[g]   = k;
    start_s[g] = 1'b1;
    ready_s[g] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start_s[g] = 1'b0;
    snapshot(g, {1'b1, 1'b1, 1'b0, 6'd0, mw[0]}, "first_word");
    for (int c = 0; c < 1000 && !seen; c++) begin
      @(posedge clk); #1;
      if (done_s[g]) begin
        seen = 1'b1;
      end else if (abort_at >= 0 && valid_s[g] && idx_s[g] == 6'(abort_at)) begin
        rst        = 1'b1;
        start_s[g] = 1'b1;
        @(posedge clk); #1;
        rst        = 1'b0;
        start_s[g] = 1'b0;
        exp_q.delete();
        snapshot(g, '0, "reset_midstream");
        return;
      end
      ready_s[g] = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      start_s[g] = repulse && !seen && ($urandom_range(0, 9) == 0);
    end
    start_s[g] = 1'b0;
    if (!seen) tmo_seq++;
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  localparam logic [255:0] KAT128 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] KAT192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] KAT256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    for (int x = 0; x < 256; x++) sbox_m[x] = sbox_calc(x);
    rc_m[0] = 8'h01;
    for (int i = 1; i < 10; i++) rc_m[i] = gmul(rc_m[i-1], 8'h02);

    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      start_s[g] = 1'b0;
      ready_s[g] = 1'b0;
      key_s[g]   = '0;
    end
    for (int g = 0; g < 3; g++) begin
      @(posedge clk); #1;
      snapshot(g, '0, "reset_state");
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_key(0, KAT128, 1'b0, 1'b0, -1, 1'b1);   @(posedge clk); #1;
    run_key(1, KAT192, 1'b0, 1'b0, -1, 1'b1);   @(posedge clk); #1;
    run_key(2, KAT256, 1'b0, 1'b0, -1, 1'b1);   @(posedge clk); #1;
    run_key(0, KAT128, 1'b1, 1'b1, -1, 1'b1);   @(posedge clk); #1;
    run_key(0, rand_key(), 1'b0, 1'b0, 20, 1'b0); @(posedge clk); #1;
    run_key(0, KAT128, 1'b1, 1'b0, -1, 1'b1);   @(posedge clk); #1;
    for (int g = 0; g < 3; g++) begin
      for (int r = 0; r < 2; r++) begin
        run_key(g, rand_key(), 1'b1, 1'b1, -1, 1'b0);
        @(posedge clk); #1;
      end
    end

    for (int g = 0; g < 3; g++) ready_s[g] = 1'b0;
    end_seq++;
    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_expansion.md
KEY_EXPANSION -- requirements
Module: key_expansion

Interface
REQ-001 The module SHALL have parameter KEY_BITS, default 128, giving the AES key length in bits; legal values are 128, 192 and 256.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit, a request to begin expansion of key.
REQ-005 The module SHALL have port key, input, KEY_BITS bits, the cipher key, sampled only on an accepted start.
REQ-006 The module SHALL have port busy, output, 1 bit, high from an accepted start until done.
REQ-007 The module SHALL have port out_valid, output, 1 bit, high when out_word holds a valid schedule word.
REQ-008 The module SHALL have port out_ready, input, 1 bit, the consumer acceptance of out_word.
REQ-009 The module SHALL have port out_word, output, 32 bits, schedule word w[i] with the first key byte in bits 31:24.
REQ-010 The module SHALL have port out_index, output, 6 bits, the index i of out_word.
REQ-011 The module SHALL have port done, output, 1 bit, a one-cycle pulse after the last word is accepted.

Function
REQ-012 The module SHALL derive Nk = KEY_BITS/32, Nr = Nk+6 and total word count T = 4*(Nr+1), giving 44, 52 or 60.
REQ-013 The module SHALL have states IDLE, EMIT and DONE, with IDLE->EMIT on start in IDLE, EMIT->DONE on the handshake of word T-1, and DONE->IDLE unconditionally after one cycle.
REQ-014 The module SHALL ignore start outside IDLE.
REQ-015 The module SHALL load key into an Nk-word window on an accepted start, with w[0] = key[KEY_BITS-1 -: 32].
REQ-016 The module SHALL assert out_valid with w[0] and out_index 0 in the cycle after start is accepted (latency 1).
REQ-017 The module SHALL complete a handshake when out_valid and out_ready are both high at a clock edge.
REQ-018 The module SHALL emit words strictly in order 0..T-1 with no gaps or repeats.
REQ-019 The module SHALL hold out_word and out_index stable while out_valid is high and out_ready is low.
REQ-020 The module SHALL sustain one word per cycle while out_ready is held high.
REQ-021 The module SHALL compute words 0..Nk-1 as the key words.
REQ-022 For i >= Nk, the module SHALL compute w[i] = w[i-Nk] ^ temp, where temp = w[i-1] modified as follows:
- if i mod Nk = 0: temp = SubWord(RotWord(w[i-1])) ^ {Rcon[i/Nk - 1], 24'h0};
- else if Nk = 8 and i mod Nk = 4: temp = SubWord(w[i-1]).
REQ-023 The module SHALL use Rcon values 01,02,04,08,10,20,40,80,1B,36 (hex) and SubWord from the team S-box table.
REQ-024 The module SHALL shift the window by one word per handshake, keeping only the last Nk words.
REQ-025 The module SHALL drive out_valid low and busy high during DONE, and done high only in DONE.
REQ-026 The module SHALL allow a start presented in the cycle after DONE (IDLE) to begin a new expansion.

Reset
REQ-027 When rst is high at a clock edge, the module SHALL enter IDLE and clear busy, out_valid, done, out_index and out_word to 0, overriding any concurrent start.
REQ-028 The module SHALL abandon an expansion interrupted by rst mid-stream, with no further words or done pulse for it.

Configuration
REQ-029 With macro KEY_EXPANSION_LAST_KEY_EN defined, the module SHALL add output last_key, KEY_BITS bits, holding words T-Nk..T-1 (w[T-Nk] in the MSBs), updated at the DONE entry edge, held until the next DONE or rst, and reset to 0.
REQ-030 Without KEY_EXPANSION_LAST_KEY_EN, the module SHALL have no last_key port or storage.

Verification
REQ-031 KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, out_ready=1 -> w[4]=a0fafe17, w[43]=b6630ca6, 44 words on consecutive cycles, done one cycle after word 43.
REQ-032 KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> w[6]=fe0c91f7, w[51]=01002202, 52 words.
REQ-033 KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> w[8]=9ba35411, w[59]=706c631e, 60 words.
REQ-034 KEY_BITS=128, random out_ready stalls, start re-pulsed mid-stream -> word sequence identical to REQ-031, out_word stable during stalls, extra start ignored.
REQ-035 rst asserted at out_index 20, then new start -> outputs zero after reset edge, new stream begins at index 0 with correct w[0].
REQ-036 KEY_EXPANSION_LAST_KEY_EN defined, REQ-031 stimulus -> last_key = d014f9a8c9ee2589e13f0cc8b6630ca6 after done.
